// File: rtl/dprs_loader_pkg.sv
// Shared definitions for the DPRS loader: load-sequencer state encoding.
package dprs_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dprs_loader.sv
// Streams bytes from a valid/ready source into the write port of a dual-port RAM,
// one byte per clock, keeping a modulo-256 checksum of the bytes loaded.
module dprs_loader
  import dprs_loader_pkg::*;
#(
  parameter int KB = 16,
  localparam int AW = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [AW:0]   len,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          ce2,
  output logic          we2,
  output logic [7:0]    d2,
  output logic [AW-1:0] a2,
  output logic          busy,
  output logic          done,
  output logic [7:0]    sum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(KB * 1024 - 1);

  state_t        state;
  state_t        stateNext;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic          accept;
  logic          startLoad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The final accept moves straight to DONE so done lines up with the last write.
  always_comb begin
    stateNext = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    startLoad = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          startLoad = 1'b1;
          stateNext = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = (remaining != '0);
        if ((remaining == '0) || (s_valid && (remaining == (AW + 1)'(1)))) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign accept = s_valid & s_ready;

  // Reset clears ce2 at the same edge, so a write pending from an abort never reaches the RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      sum       <= '0;
      ce2       <= 1'b0;
      we2       <= 1'b1;
      d2        <= '0;
      a2        <= '0;
    end else begin
      ce2 <= 1'b0;
      we2 <= 1'b1;
      if (startLoad) begin
        ptr       <= addr;
        remaining <= len;
        sum       <= '0;
      end else if (accept) begin
        ce2       <= 1'b1;
        we2       <= 1'b0;
        d2        <= s_data;
        a2        <= ptr;
        ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
        remaining <= remaining - (AW + 1)'(1);
        sum       <= sum + s_data;
      end
    end
  end

endmodule

// File: tb/tb_dprs_loader.sv
// Directed bench for dprs_loader: a transaction-level model predicts every output
// each cycle, and per-scenario literal checks pin the model to known answers.
module tb_dprs_loader;

  localparam int KB   = 16;
  localparam int AW   = 14;
  localparam int SIZE = KB * 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] addr;
  logic [AW:0]   len;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          ce2;
  logic          we2;
  logic [7:0]    d2;
  logic [AW-1:0] a2;
  logic          busy;
  logic          done;
  logic [7:0]    sum;

  dprs_loader #(.KB(KB)) dut (
    .clock(clock), .reset(reset), .start(start), .addr(addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ce2(ce2), .we2(we2), .d2(d2), .a2(a2),
    .busy(busy), .done(done), .sum(sum)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit armed       = 0;

  // Model state: a load is either running, finishing (done cycle) or absent.
  bit  mActive, mDone, mWrite;
  int  mRem, mPtr, mA, mD, mSum;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;
  wr_t wlog[$];
  int  doneCount;
  int  doneSum;
  int  doneCyc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [AW-1:0] ad, input logic [AW:0] ln,
                               input logic v, input logic [7:0] d, input logic rst);
    start   = st;
    addr    = ad;
    len     = ln;
    s_valid = v;
    s_data  = d;
    reset   = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clearLog();
    wlog.delete();
    doneCount = 0;
    doneSum   = -1;
    doneCyc   = -1;
  endtask

  function automatic int logAddr(input int i);
    return (wlog.size() > i) ? wlog[i].a : -1;
  endfunction

  function automatic int logData(input int i);
    return (wlog.size() > i) ? wlog[i].d : -1;
  endfunction

  // Model: one accepted byte becomes one write next cycle; the done cycle follows the last accept.
  always @(posedge clock) begin
    bit acc;
    bit wasIdle;
    cyc++;
    if (reset) begin
      armed   = 1;
      mActive = 0; mDone = 0; mWrite = 0;
      mRem = 0; mPtr = 0; mA = 0; mD = 0; mSum = 0;
    end else begin
      wasIdle = !mActive && !mDone;
      acc     = mActive && (mRem != 0) && s_valid;
      mDone   = 0;
      mWrite  = acc;
      if (acc) begin
        mA   = mPtr;
        mD   = s_data;
        mPtr = (mPtr + 1) % SIZE;
        mRem = mRem - 1;
        mSum = (mSum + s_data) % 256;
      end
      if (mActive && mRem == 0) begin
        mActive = 0;
        mDone   = 1;
      end else if (wasIdle && start) begin
        mPtr = addr;
        mRem = len;
        mSum = 0;
        if (len == 0) mDone = 1;
        else mActive = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      checkOutput("ce2", ce2, mWrite);
      checkOutput("we2", we2, !mWrite);
      checkOutput("a2", a2, mA);
      checkOutput("d2", d2, mD);
      checkOutput("sum", sum, mSum);
      checkOutput("done", done, mDone);
      checkOutput("busy", busy, mActive || mDone);
      checkOutput("s_ready", s_ready, mActive && (mRem != 0));
      if (ce2 === 1'b1) wlog.push_back('{a: int'(a2), d: int'(d2), c: cyc});
      if (done === 1'b1) begin
        doneCount++;
        doneSum = sum;
        doneCyc = cyc;
      end
    end
  end

  initial begin
    int startCyc;
    clearLog();
    applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, 1'b1);
    checkOutput("reset we2", we2, 1'b1);
    checkOutput("reset busy", busy, 1'b0);

    // Basic back-to-back load.
    clearLog();
    applyStimulus(1'b1, 14'h0100, 15'd4, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h44, 1'b0);
    idleCycles(3);
    checkOutput("b2b writes", wlog.size(), 4);
    checkOutput("b2b addr0", logAddr(0), 32'h0100);
    checkOutput("b2b addr3", logAddr(3), 32'h0103);
    checkOutput("b2b data2", logData(2), 32'h33);
    checkOutput("b2b span", (wlog.size() == 4) ? wlog[3].c - wlog[0].c : -1, 3);
    checkOutput("b2b sum", doneSum, 32'hAA);
    checkOutput("b2b done pulses", doneCount, 1);

    // Address wrap at the top of the RAM.
    clearLog();
    applyStimulus(1'b1, 14'h3FFE, 15'd3, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h03, 1'b0);
    idleCycles(3);
    checkOutput("wrap addr0", logAddr(0), 32'h3FFE);
    checkOutput("wrap addr1", logAddr(1), 32'h3FFF);
    checkOutput("wrap addr2", logAddr(2), 32'h0000);
    checkOutput("wrap sum", doneSum, 32'h06);

    // Zero-length load.
    clearLog();
    applyStimulus(1'b1, 14'h0040, 15'd0, 1'b1, 8'h55, 1'b0);
    startCyc = cyc;
    idleCycles(3);
    checkOutput("len0 writes", wlog.size(), 0);
    checkOutput("len0 done pulses", doneCount, 1);
    checkOutput("len0 done latency", doneCyc - startCyc, 0);
    checkOutput("len0 sum", doneSum, 0);

    // Stalling source.
    clearLog();
    applyStimulus(1'b1, 14'h0010, 15'd3, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 8'h06, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 8'h07, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h08, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 8'h09, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h0A, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h0B, 1'b0);
    idleCycles(2);
    checkOutput("stall writes", wlog.size(), 3);
    checkOutput("stall data1", logData(1), 32'h08);
    checkOutput("stall addr2", logAddr(2), 32'h0012);
    checkOutput("stall sum", doneSum, 32'h17);

    // Abort by reset on the second accept.
    clearLog();
    applyStimulus(1'b1, 14'h0200, 15'd4, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b1, 14'h0300, 15'd2, 1'b1, 8'hA2, 1'b1);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort ce2", ce2, 1'b0);
    checkOutput("abort a2", a2, 32'h0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'hA3, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'hA4, 1'b0);
    idleCycles(2);
    checkOutput("abort writes", wlog.size(), 1);
    checkOutput("abort data0", logData(0), 32'hA1);
    checkOutput("abort done pulses", doneCount, 0);

    // Start while busy is ignored.
    clearLog();
    applyStimulus(1'b1, 14'h0300, 15'd3, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 14'h0050, 15'd2, 1'b1, 8'h20, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h30, 1'b0);
    idleCycles(3);
    checkOutput("restart writes", wlog.size(), 3);
    checkOutput("restart addr1", logAddr(1), 32'h0301);
    checkOutput("restart addr2", logAddr(2), 32'h0302);
    checkOutput("restart sum", doneSum, 32'h60);
    checkOutput("restart done pulses", doneCount, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
